// File: rtl/zero_scan_scheduler.sv
// zero_scan_scheduler
//
// Round-robin front end for a single serial two-zero scan engine. NREQ
// requesters each offer a WIDTH-bit word. One requester is granted at a time.
// Its word is shifted LSB-first through an S0/S1/S2 zero-count machine, and a
// tagged hit/position result is then reported.
//
// Handshake: a requester holds req high until it sees its one-cycle gnt pulse.
// gnt marks the cycle after its word was captured. req is sampled only in IDLE,
// so a requester with no further word drops req in the cycle after gnt. A
// requester that keeps req high is simply re-arbitrated in the next IDLE cycle.
// done is a one-cycle pulse. done_id, hit and hit_pos stay valid from that
// pulse until the next one.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous, active-low reset
//   req      - per-requester request levels
//   data     - requester i's word is data[i*WIDTH +: WIDTH]
//   gnt      - one-hot capture pulse
//   busy     - high in SCAN and DONE
//   done     - one-cycle result-valid pulse
//   done_id  - index of the requester being reported
//   hit      - the word held two zero bits (not necessarily adjacent)
//   hit_pos  - bit index of the second zero; 0 when hit is 0
//   state    - FSM state: IDLE=0, SCAN=1, DONE=2
//
// Build option: define ZD_EARLY_EXIT_EN to end the scan on the edge that
// examines the second zero. The reported results are the same either way.
// Only the latency changes.

module zero_scan_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ),
    parameter int PW    = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [IDW-1:0]          done_id,
    output logic                    hit,
    output logic [PW-1:0]           hit_pos,
    output logic [1:0]              state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } zc_t;

    state_t           st;
    zc_t              zc;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cur_id;
    logic [PW-1:0]    bit_idx;
    logic [WIDTH-1:0] sreg;
    logic             scan_hit;
    logic [PW-1:0]    scan_pos;

    assign state = st;

    // ------------------------------------------------------------------
    // Round-robin selection: the first set req bit at or after ptr,
    // wrapping modulo NREQ.
    // ------------------------------------------------------------------
    logic             sel_vld;
    logic [IDW-1:0]   sel_id;
    logic [NREQ-1:0]  sel_oh;
    logic [IDW-1:0]   ptr_nxt;
    logic [IDW:0]     cand_sum;
    logic [IDW-1:0]   cand;

    always_comb begin
        sel_vld  = 1'b0;
        sel_id   = '0;
        sel_oh   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, ptr} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!sel_vld && req[cand]) begin
                sel_vld      = 1'b1;
                sel_id       = cand;
                sel_oh[cand] = 1'b1;
            end
        end
        ptr_nxt = (sel_id == IDW'(NREQ-1)) ? '0 : sel_id + 1'b1;
    end

    // ------------------------------------------------------------------
    // Zero-count step for the bit currently at the bottom of the shift
    // register. Once in S2 the count and the recorded position are frozen,
    // so later zeros never move hit_pos.
    // ------------------------------------------------------------------
    logic          bit_now;
    zc_t           zc_nxt;
    logic          hit_nxt;
    logic [PW-1:0] pos_nxt;
    logic          scan_end;

    always_comb begin
        bit_now = sreg[0];
        zc_nxt  = zc;
        hit_nxt = scan_hit;
        pos_nxt = scan_pos;
        if (!bit_now) begin
            case (zc)
                S0: zc_nxt = S1;
                S1: begin
                    zc_nxt  = S2;
                    hit_nxt = 1'b1;
                    pos_nxt = bit_idx;
                end
                default: zc_nxt = zc;
            endcase
        end
`ifdef ZD_EARLY_EXIT_EN
        scan_end = (bit_idx == PW'(WIDTH-1)) || (!bit_now && (zc == S1));
`else
        scan_end = (bit_idx == PW'(WIDTH-1));
`endif
    end

    // ------------------------------------------------------------------
    // Scheduler FSM with registered outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= IDLE;
            zc       <= S0;
            ptr      <= '0;
            cur_id   <= '0;
            bit_idx  <= '0;
            sreg     <= '0;
            scan_hit <= 1'b0;
            scan_pos <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
            hit      <= 1'b0;
            hit_pos  <= '0;
        end else begin
            // gnt and done are single-cycle pulses.
            gnt  <= '0;
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (sel_vld) begin
                        sreg     <= data[int'(sel_id)*WIDTH +: WIDTH];
                        gnt      <= sel_oh;
                        cur_id   <= sel_id;
                        ptr      <= ptr_nxt;
                        zc       <= S0;
                        bit_idx  <= '0;
                        scan_hit <= 1'b0;
                        scan_pos <= '0;
                        busy     <= 1'b1;
                        st       <= SCAN;
                    end
                end
                SCAN: begin
                    sreg     <= sreg >> 1;
                    zc       <= zc_nxt;
                    scan_hit <= hit_nxt;
                    scan_pos <= pos_nxt;
                    bit_idx  <= bit_idx + 1'b1;
                    if (scan_end) begin
                        // The result is published on the edge that enters DONE.
                        st      <= DONE;
                        done    <= 1'b1;
                        done_id <= cur_id;
                        hit     <= hit_nxt;
                        hit_pos <= pos_nxt;
                    end
                end
                DONE: begin
                    // Always pass through IDLE before the next grant.
                    busy <= 1'b0;
                    st   <= IDLE;
                end
                default: begin
                    busy <= 1'b0;
                    st   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_scan_scheduler.sv
// Testbench for zero_scan_scheduler (NREQ=4, WIDTH=8).
// Directed requests are issued with hand-computed expected results.
// The expectations go into queues.
// A monitor checks each gnt pulse and each done pulse against those queues.
// Latency is counted from the cycle gnt is seen to the cycle done is seen:
//   full scan:  WIDTH cycles
//   early exit: second-zero position + 1 cycles

module tb_zero_scan_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;
    localparam int PW    = 3;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic                  hit;
    logic [PW-1:0]         hit_pos;
    logic [1:0]            state;

    zero_scan_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .data    (data),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .hit     (hit),
        .hit_pos (hit_pos),
        .state   (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    // exp_gnt_q entry: {back_to_back, gnt one-hot}
    logic [4:0]  exp_gnt_q[$];
    // exp_res_q entry: {latency[7:0], id[1:0], hit, pos[2:0]}
    logic [13:0] exp_res_q[$];

    function automatic int lat_of(input logic h, input int p);
`ifdef ZD_EARLY_EXIT_EN
        return h ? p + 1 : WIDTH;
`else
        return WIDTH;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic h, input int p, input logic b2b);
        exp_gnt_q.push_back({b2b, 4'(1 << id)});
        exp_res_q.push_back({8'(lat_of(h, p)), 2'(id), h, 3'(p)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_gnt_count(input int n);
        int seen = 0;
        for (int i = 0; i < 300 && seen < n; i++) begin
            @(negedge clk);
            if (gnt != '0) seen++;
        end
        req = '0;
        if (seen < n) begin
            n_cmp++;
            n_fail++;
            $display("FAIL gnt_timeout: got %0d grants, expected %0d", seen, n);
        end
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy && state == 2'd0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy %b state %0d, expected idle", busy, state);
        end
    endtask

    task automatic run(input logic [NREQ-1:0] mask, input int ngnt);
        req = mask;
        wait_gnt_count(ngnt);
        wait_idle();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        int last_gnt  = 0;
        int last_done = 0;
        logic [4:0]  eg;
        logic [13:0] er;
        forever begin
            @(negedge clk);
            if (reset && gnt != '0) begin
                if (exp_gnt_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL gnt_unexpected: got %b, expected none", gnt);
                end else begin
                    eg = exp_gnt_q.pop_front();
                    check("gnt", 32'(gnt), 32'(eg[3:0]));
                    if (eg[4]) check("gnt_spacing", 32'(cyc - last_done), 32'd2);
                end
                last_gnt = cyc;
            end
            if (reset && done) begin
                if (exp_res_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_unexpected: got id %0d hit %b pos %0d, expected none",
                             done_id, hit, hit_pos);
                end else begin
                    er = exp_res_q.pop_front();
                    check("result_id_hit_pos", 32'({done_id, hit, hit_pos}), 32'(er[5:0]));
                    check("done_latency", 32'(cyc - last_gnt), 32'(er[13:6]));
                end
                last_done = cyc;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        req   = '0;
        // word3 = 0111_1111, word2 = 1011_1110, word1 = 1111_1100, word0 = 1111_1111
        data  = {8'h7F, 8'hBE, 8'hFC, 8'hFF};

        repeat (3) @(negedge clk);
        check("rst_state",   32'(state),   32'd0);
        check("rst_gnt",     32'(gnt),     32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'(done),    32'd0);
        check("rst_done_id", 32'(done_id), 32'd0);
        check("rst_hit",     32'(hit),     32'd0);
        check("rst_hit_pos", 32'(hit_pos), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // No hit, adjacent zeros, separated zeros. The pointer moves 0 -> 1 -> 2 -> 3.
        push_exp(0, 1'b0, 0, 1'b0); run(4'b0001, 1);
        push_exp(1, 1'b1, 1, 1'b0); run(4'b0010, 1);
        push_exp(2, 1'b1, 6, 1'b0); run(4'b0100, 1);

        // Reset during scan cycle 4. The held result (id2/hit/pos6) must clear.
        exp_gnt_q.push_back({1'b0, 4'b0001});
        req = 4'b0001;
        wait_gnt_count(1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rst_state",   32'(state),   32'd0);
        check("mid_rst_gnt",     32'(gnt),     32'd0);
        check("mid_rst_busy",    32'(busy),    32'd0);
        check("mid_rst_done",    32'(done),    32'd0);
        check("mid_rst_done_id", 32'(done_id), 32'd0);
        check("mid_rst_hit",     32'(hit),     32'd0);
        check("mid_rst_hit_pos", 32'(hit_pos), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // The pointer is back at 0, so req=0101 grants 0 first and then 2.
        push_exp(0, 1'b0, 0, 1'b0);
        push_exp(2, 1'b1, 6, 1'b1);
        run(4'b0101, 2);

        // Single zero: no hit. The pointer wraps from 3 to 0.
        push_exp(3, 1'b0, 0, 1'b0); run(4'b1000, 1);

        // All requests held: rotation 0,1,2,3,0 with back-to-back spacing.
        push_exp(0, 1'b0, 0, 1'b0);
        push_exp(1, 1'b1, 1, 1'b1);
        push_exp(2, 1'b1, 6, 1'b1);
        push_exp(3, 1'b0, 0, 1'b1);
        push_exp(0, 1'b0, 0, 1'b1);
        run(4'b1111, 5);

        // Wrap-around: put the pointer at 3, then req=1001 grants 3 and then 0.
        push_exp(2, 1'b1, 6, 1'b0); run(4'b0100, 1);
        push_exp(3, 1'b0, 0, 1'b0);
        push_exp(0, 1'b0, 0, 1'b1);
        run(4'b1001, 2);

        repeat (5) @(negedge clk);
        check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("res_queue_drained", 32'(exp_res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
